// File: rtl/trap_filter_ctrl_pkg.sv
// ============================================================================
// trap_ctrl_pkg : shared types and constants for the trapezoidal filter control
// Revision: 1.0
// ============================================================================
`default_nettype none

package trap_ctrl_pkg;

  localparam int TRAP_DATA_W   = 16;
  localparam int TRAP_KL_W     = 8;
  localparam int TRAP_M_W      = 16;
  localparam int TRAP_PIPE_LAT = 4;
  localparam int TRAP_K_DEF    = 4;
  localparam int TRAP_L_DEF    = 8;
  localparam int TRAP_M1_DEF   = 16;
  localparam int TRAP_M2_DEF   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [TRAP_KL_W-1:0] k;
    logic [TRAP_KL_W-1:0] l;
    logic [TRAP_M_W-1:0]  m1;
    logic [TRAP_M_W-1:0]  m2;
  } trap_coef_t;

endpackage

`default_nettype wire

// File: rtl/trap_filter_ctrl_if.sv
// ============================================================================
// trap_filter_ctrl_if : config, sample, filter and status signals of the control
// Revision: 1.0
// ============================================================================
`default_nettype none

interface trap_filter_ctrl_if
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_W = TRAP_DATA_W,
  parameter int KL_W   = TRAP_KL_W,
  parameter int M_W    = TRAP_M_W
);

  logic                     enable;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [KL_W-1:0]          cfg_k;
  logic [KL_W-1:0]          cfg_l;
  logic [M_W-1:0]           cfg_m1;
  logic [M_W-1:0]           cfg_m2;
  logic                     cfg_err;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     filt_clear;
  logic signed [DATA_W-1:0] filt_in_data;
  logic [KL_W-1:0]          k_act;
  logic [KL_W-1:0]          l_act;
  logic [M_W-1:0]           m1_act;
  logic [M_W-1:0]           m2_act;
  logic signed [DATA_W-1:0] filt_out_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [2:0]               state;
  logic                     out_ovf;

  modport master (
    output enable, cfg_valid, cfg_k, cfg_l, cfg_m1, cfg_m2,
           in_valid, in_data, filt_out_data,
    input  cfg_ready, cfg_err, filt_clear, filt_in_data,
           k_act, l_act, m1_act, m2_act, out_valid, out_data, state, out_ovf
  );

  modport slave (
    input  enable, cfg_valid, cfg_k, cfg_l, cfg_m1, cfg_m2,
           in_valid, in_data, filt_out_data,
    output cfg_ready, cfg_err, filt_clear, filt_in_data,
           k_act, l_act, m1_act, m2_act, out_valid, out_data, state, out_ovf
  );

endinterface

`default_nettype wire

// File: rtl/trap_filter_ctrl_cfg_check.sv
// ============================================================================
// trap_ctrl_cfg_check : combinational legality check of a requested coefficient set
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_ctrl_cfg_check
  import trap_ctrl_pkg::*;
(
  input  trap_coef_t coef,
  output logic       valid
);

  localparam int SUM_W = TRAP_KL_W + 1;
  // The flush adds one to k+l, so the sum must stay two below the KL_W range.
  localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'((1 << TRAP_KL_W) - 2);

  logic [SUM_W-1:0] sum;
  logic             unused_m;

  assign sum      = SUM_W'(coef.k) + SUM_W'(coef.l);
  assign valid    = (coef.k != '0) && (coef.l >= coef.k) && (sum <= SUM_MAX);
  assign unused_m = ^{coef.m1, coef.m2};

endmodule

`default_nettype wire

// File: rtl/trap_filter_ctrl.sv
// ============================================================================
// trap_filter_ctrl : sequencer/config owner for the trapezoidal shaping filter.
// Optional build macro TRAP_CTRL_OVF_DET_EN adds the sticky output-overflow flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_filter_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_W   = TRAP_DATA_W,
  parameter int KL_W     = TRAP_KL_W,
  parameter int M_W      = TRAP_M_W,
  parameter int PIPE_LAT = TRAP_PIPE_LAT,
  parameter int K_DEF    = TRAP_K_DEF,
  parameter int L_DEF    = TRAP_L_DEF,
  parameter int M1_DEF   = TRAP_M1_DEF,
  parameter int M2_DEF   = TRAP_M2_DEF
) (
  input  logic               clk,
  input  logic               reset,
  trap_filter_ctrl_if.slave  bus
);

  localparam int CNT_W = KL_W + 1;

  ctrl_state_t              state_q;
  ctrl_state_t              state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  trap_coef_t               coef_q;
  trap_coef_t               coef_req;
  trap_coef_t               coef_next;
  logic                     cfg_ok;
  logic                     cfg_ready;
  logic                     cfg_acc;
  logic                     cfg_take;
  logic                     cfg_err_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic signed [DATA_W-1:0] filt_in_q;
  logic [CNT_W-1:0]         flush_cnt;
  logic [CNT_W-1:0]         settle_cnt;
  logic                     live;

  assign coef_req = '{k: bus.cfg_k, l: bus.cfg_l, m1: bus.cfg_m1, m2: bus.cfg_m2};

  trap_ctrl_cfg_check u_cfg_check (
    .coef  (coef_req),
    .valid (cfg_ok)
  );

  assign cfg_ready = (state_q != ST_FLUSH);
  assign cfg_acc   = bus.cfg_valid && cfg_ready;
  assign cfg_take  = cfg_acc && cfg_ok;
  assign coef_next = cfg_take ? coef_req : coef_q;

  // Flush length follows the coefficients that are active from the next edge on.
  assign flush_cnt  = CNT_W'(coef_next.k) + CNT_W'(coef_next.l) + CNT_W'(1);
  assign settle_cnt = CNT_W'(coef_q.k) + CNT_W'(coef_q.l) + CNT_W'(PIPE_LAT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FLUSH;
          cnt_d   = flush_cnt;
        end
        ST_FLUSH: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_SETTLE;
            cnt_d   = settle_cnt;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cfg_take) begin
            state_d = ST_FLUSH;
            cnt_d   = flush_cnt;
          end else if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (cfg_take) begin
            state_d = ST_FLUSH;
            cnt_d   = flush_cnt;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Samples pass only while the filter stays out of clear on both sides of the edge.
  assign live = ((state_q == ST_SETTLE) || (state_q == ST_RUN)) &&
                ((state_d == ST_SETTLE) || (state_d == ST_RUN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      coef_q      <= '{k: KL_W'(K_DEF), l: KL_W'(L_DEF), m1: M_W'(M1_DEF), m2: M_W'(M2_DEF)};
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      filt_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coef_q      <= coef_next;
      cfg_err_q   <= cfg_acc && !cfg_ok;
      out_valid_q <= (state_d == ST_RUN);
      if (state_d == ST_RUN) begin
        out_data_q <= bus.filt_out_data;
      end
      filt_in_q   <= (live && bus.in_valid) ? bus.in_data : '0;
    end
  end

`ifdef TRAP_CTRL_OVF_DET_EN
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (cfg_take) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ST_RUN) &&
                 ((bus.filt_out_data == DATA_MAX) || (bus.filt_out_data == DATA_MIN))) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.out_ovf = ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.cfg_ready    = cfg_ready;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.filt_clear   = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
  assign bus.filt_in_data = filt_in_q;
  assign bus.k_act        = coef_q.k;
  assign bus.l_act        = coef_q.l;
  assign bus.m1_act       = coef_q.m1;
  assign bus.m2_act       = coef_q.m2;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.state        = state_q;

endmodule

`default_nettype wire
